// File: rtl/step_seq_pkg.sv
// Shared types and constants for the step sequencer that drives the
// 12-note generator's Select mask and nStart restart line.
package step_seq_pkg;
    typedef enum logic [1:0] {IDLE, RESYNC, SOUND, REST} state_e;

    localparam int NOTES = 12;

    localparam int NOTE_C  = 0;
    localparam int NOTE_CS = 1;
    localparam int NOTE_D  = 2;
    localparam int NOTE_DS = 3;
    localparam int NOTE_E  = 4;
    localparam int NOTE_F  = 5;
    localparam int NOTE_FS = 6;
    localparam int NOTE_G  = 7;
    localparam int NOTE_GS = 8;
    localparam int NOTE_A  = 9;
    localparam int NOTE_AS = 10;
    localparam int NOTE_B  = 11;

    localparam int DEFAULT_STEPS = 16;
    localparam int DEFAULT_CW    = 24;
endpackage

// File: rtl/step_pattern_ram.sv
// STEPS x 12 pattern register file. Writes are synchronous and reads are
// combinational; a write to the address being read is forwarded at once.
module step_pattern_ram
    import step_seq_pkg::*;
#(
    parameter int STEPS = DEFAULT_STEPS,
    parameter int AW    = $clog2(STEPS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [NOTES-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [NOTES-1:0] rdata_o
);
    logic [NOTES-1:0] mem_q [STEPS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STEPS; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Bypass lets a same-cycle write reach the RESYNC latch.
    assign rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
endmodule

// File: rtl/step_scheduler.sv
// Step sequencer: plays the pattern in a loop, restarting all oscillators
// (nStart low) for one cycle at the start of every step.
module step_scheduler
    import step_seq_pkg::*;
#(
    parameter int STEPS = DEFAULT_STEPS,
    parameter int CW    = DEFAULT_CW,
    localparam int AW   = $clog2(STEPS)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Stop,
    input  logic             WrEn,
    input  logic [AW-1:0]    WrAddr,
    input  logic [NOTES-1:0] WrData,
    input  logic [CW-1:0]    StepPeriod,
    input  logic [CW-1:0]    GateLen,
    output logic [NOTES-1:0] Select,
    output logic             nStart,
    output logic [AW-1:0]    Step,
    output logic             StepStrobe,
    output logic             Playing
);
    state_e           state_q, state_d;
    logic [AW-1:0]    step_q, step_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    per_q, per_d;
    logic [CW-1:0]    gate_q, gate_d;
    logic [NOTES-1:0] sel_q, sel_d;
    logic             nstart_q, strobe_q, playing_q;
    logic [NOTES-1:0] rd_mask;

    step_pattern_ram #(.STEPS(STEPS), .AW(AW)) u_ram (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .we_i    (WrEn),
        .waddr_i (WrAddr),
        .wdata_i (WrData),
        .raddr_i (step_q),
        .rdata_o (rd_mask)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        gate_d  = gate_q;
        sel_d   = '0;
        case (state_q)
            IDLE: ;
            RESYNC: begin
                // Period is clamped to 2 so every step has a restart cycle plus one more.
                per_d   = (StepPeriod < CW'(2)) ? CW'(2) : StepPeriod;
                gate_d  = GateLen;
                cnt_d   = CW'(1);
                state_d = (GateLen > CW'(1)) ? SOUND : REST;
                sel_d   = (GateLen > CW'(1)) ? rd_mask : '0;
            end
            SOUND: begin
                cnt_d = cnt_q + CW'(1);
                sel_d = sel_q;
                if (cnt_q == per_q - CW'(1)) begin
                    state_d = RESYNC;
                    step_d  = step_q + AW'(1);
                    cnt_d   = '0;
                    sel_d   = '0;
                end else if (cnt_q + CW'(1) == gate_q) begin
                    state_d = REST;
                    sel_d   = '0;
                end
            end
            REST: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == per_q - CW'(1)) begin
                    state_d = RESYNC;
                    step_d  = step_q + AW'(1);
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Stop outranks Start; Step is deliberately left where it was.
        if (Stop) begin
            state_d = IDLE;
            step_d  = step_q;
            cnt_d   = '0;
            sel_d   = '0;
        end else if (Start) begin
            state_d = RESYNC;
            step_d  = '0;
            cnt_d   = '0;
            sel_d   = '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            step_q    <= '0;
            cnt_q     <= '0;
            per_q     <= '0;
            gate_q    <= '0;
            sel_q     <= '0;
            nstart_q  <= 1'b1;
            strobe_q  <= 1'b0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            gate_q    <= gate_d;
            sel_q     <= sel_d;
            nstart_q  <= (state_d != RESYNC);
            strobe_q  <= (state_d == RESYNC);
            playing_q <= (state_d != IDLE);
        end
    end

    assign Select     = sel_q;
    assign nStart     = nstart_q;
    assign Step       = step_q;
    assign StepStrobe = strobe_q;
    assign Playing    = playing_q;
endmodule

// File: tb/tb_step_scheduler.sv
// Bench for step_scheduler: per-cycle expected outputs are queued when
// stimulus is driven and popped/compared every cycle after the clock edge.
module tb_step_scheduler;
    logic        Clock, Reset, Start, Stop, WrEn;
    logic [3:0]  WrAddr;
    logic [11:0] WrData;
    logic [23:0] StepPeriod, GateLen;
    logic [11:0] Select;
    logic        nStart, StepStrobe, Playing;
    logic [3:0]  Step;

    step_scheduler #(.STEPS(16), .CW(24)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .StepPeriod(StepPeriod), .GateLen(GateLen),
        .Select(Select), .nStart(nStart), .Step(Step),
        .StepStrobe(StepStrobe), .Playing(Playing)
    );

    typedef struct {
        logic [11:0] sel;
        logic        nst;
        logic        stb;
        logic [3:0]  step;
        logic        ply;
        int          tag;
    } exp_t;

    typedef struct {
        logic [11:0] m0;
        logic [11:0] m1;
        logic [23:0] per;
        logic [23:0] gate;
        int          len;
        int          snd;
    } vec_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cur_tag = 0;
    int   cyc = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) begin
        cyc++;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (Select !== e.sel || nStart !== e.nst || StepStrobe !== e.stb ||
                Step !== e.step || Playing !== e.ply) begin
                n_fail++;
                $display("FAIL out tag=%0d cyc=%0d got sel=%h nst=%b stb=%b step=%0d ply=%b want sel=%h nst=%b stb=%b step=%0d ply=%b",
                         e.tag, cyc, Select, nStart, StepStrobe, Step, Playing,
                         e.sel, e.nst, e.stb, e.step, e.ply);
            end
        end
    end

    task automatic nxt();
        @(negedge Clock);
    endtask

    task automatic push_rec(input logic [11:0] sel, input logic nst, input logic stb,
                            input logic [3:0] step, input logic ply);
        exp_t r;
        r.sel = sel; r.nst = nst; r.stb = stb; r.step = step; r.ply = ply; r.tag = cur_tag;
        q.push_back(r);
    endtask

    task automatic idle(input logic [3:0] step);
        push_rec(12'h000, 1'b1, 1'b0, step, 1'b0);
    endtask

    // One full step: restart cycle, then snd cycles of mask, silence to len.
    task automatic push_step(input logic [11:0] mask, input int len, input int snd,
                             input logic [3:0] step);
        push_rec(12'h000, 1'b0, 1'b1, step, 1'b1);
        for (int i = 1; i < len; i++)
            push_rec((i <= snd) ? mask : 12'h000, 1'b1, 1'b0, step, 1'b1);
    endtask

    task automatic wait_empty();
        int k = 0;
        while (q.size() != 0 && k < 300) begin
            nxt();
            k++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout tag=%0d pending=%0d want 0", cur_tag, q.size());
            q.delete();
        end
    endtask

    task automatic play_step(input logic [11:0] mask, input int len, input int snd,
                             input logic [3:0] step);
        wait_empty();
        push_step(mask, len, snd, step);
    endtask

    task automatic start_step0(input logic [11:0] mask, input int len, input int snd);
        wait_empty();
        Start = 1'b1;
        push_step(mask, len, snd, 4'd0);
        nxt();
        Start = 1'b0;
    endtask

    task automatic stop_at(input logic [3:0] step);
        wait_empty();
        Stop = 1'b1;
        idle(step);
        nxt();
        Stop = 1'b0;
        idle(step);
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        nxt();
        WrEn = 1'b1; WrAddr = a; WrData = d;
        nxt();
        WrEn = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{12'h001, 12'h880, 24'd8, 24'd4,   8, 3};
        vecs[1] = '{12'h00F, 12'hF00, 24'd3, 24'd100, 3, 2};
        vecs[2] = '{12'h3C3, 12'h111, 24'd5, 24'd1,   5, 0};
        vecs[3] = '{12'h3C3, 12'h111, 24'd5, 24'd0,   5, 0};
        vecs[4] = '{12'h081, 12'h402, 24'd0, 24'd5,   2, 1};
        vecs[5] = '{12'h204, 12'h010, 24'd1, 24'd5,   2, 1};
        vecs[6] = '{12'hABC, 12'h543, 24'd6, 24'd6,   6, 5};
        vecs[7] = '{12'h0F0, 12'hF0F, 24'd6, 24'd2,   6, 1};
        vecs[8] = '{12'h000, 12'h7E7, 24'd4, 24'd3,   4, 2};

        Reset = 1'b1; Start = 1'b0; Stop = 1'b0; WrEn = 1'b0;
        WrAddr = '0; WrData = '0; StepPeriod = 24'd8; GateLen = 24'd4;

        idle(4'd0);
        idle(4'd0);
        nxt();
        nxt();
        Reset = 1'b0;
        idle(4'd0);

        for (int i = 0; i < 9; i++) begin
            cur_tag = 1 + i;
            wr(4'd0, vecs[i].m0);
            wr(4'd1, vecs[i].m1);
            StepPeriod = vecs[i].per;
            GateLen    = vecs[i].gate;
            start_step0(vecs[i].m0, vecs[i].len, vecs[i].snd);
            play_step(vecs[i].m1, vecs[i].len, vecs[i].snd, 4'd1);
            stop_at(4'd1);
        end

        // Full pattern wrap 15 -> 0 at a 3-clock period.
        cur_tag = 20;
        for (int s = 0; s < 16; s++) wr(4'(s), 12'hFFF);
        StepPeriod = 24'd3; GateLen = 24'd100;
        start_step0(12'hFFF, 3, 2);
        for (int s = 1; s < 16; s++) play_step(12'hFFF, 3, 2, 4'(s));
        play_step(12'hFFF, 3, 2, 4'd0);
        play_step(12'hFFF, 3, 2, 4'd1);
        stop_at(4'd1);

        // Stop mid-SOUND at step 5, then Start+Stop together while idle.
        cur_tag = 21;
        StepPeriod = 24'd8; GateLen = 24'd8;
        start_step0(12'hFFF, 8, 7);
        for (int s = 1; s < 5; s++) play_step(12'hFFF, 8, 7, 4'(s));
        wait_empty();
        push_rec(12'h000, 1'b0, 1'b1, 4'd5, 1'b1);
        push_rec(12'hFFF, 1'b1, 1'b0, 4'd5, 1'b1);
        push_rec(12'hFFF, 1'b1, 1'b0, 4'd5, 1'b1);
        wait_empty();
        Stop = 1'b1;
        idle(4'd5);
        nxt();
        Start = 1'b1;
        idle(4'd5);
        nxt();
        Start = 1'b0; Stop = 1'b0;
        idle(4'd5);

        // Write during RESYNC is bypassed; later write and period change wait.
        cur_tag = 22;
        wr(4'd0, 12'h0AA);
        wr(4'd1, 12'h123);
        StepPeriod = 24'd4; GateLen = 24'd4;
        wait_empty();
        Start = 1'b1;
        push_step(12'h555, 4, 3, 4'd0);
        nxt();
        Start = 1'b0;
        WrEn = 1'b1; WrAddr = 4'd0; WrData = 12'h555;
        nxt();
        WrData = 12'h0F0;
        StepPeriod = 24'd6;
        nxt();
        WrEn = 1'b0;
        play_step(12'h123, 6, 3, 4'd1);
        stop_at(4'd1);

        // Reset mid-SOUND clears outputs and the pattern.
        cur_tag = 23;
        StepPeriod = 24'd8; GateLen = 24'd8;
        wait_empty();
        Start = 1'b1;
        push_rec(12'h000, 1'b0, 1'b1, 4'd0, 1'b1);
        push_rec(12'h0F0, 1'b1, 1'b0, 4'd0, 1'b1);
        push_rec(12'h0F0, 1'b1, 1'b0, 4'd0, 1'b1);
        nxt();
        Start = 1'b0;
        wait_empty();
        Reset = 1'b1;
        idle(4'd0);
        nxt();
        Reset = 1'b0;
        idle(4'd0);
        StepPeriod = 24'd4; GateLen = 24'd4;
        start_step0(12'h000, 4, 3);
        stop_at(4'd0);

        wait_empty();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/step_scheduler.md
Name: step_scheduler

Overview:
- Sequencing controller for the 12-note audio generator; drives its 12-bit `Select` note mask and its active-low oscillator restart `nStart`.
- Holds a STEPS-entry pattern of note masks, written by the UI.
- Plays the pattern in a loop at a programmable step period and gate length.
- Restarts all oscillators at every step boundary so each note begins at phase 0.

Parameters:
- STEPS, 16, number of pattern steps (power of two, 2..64).
- CW, 24, width of the period/gate counters in clocks.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse; begin (or restart) playback at step 0.
- Stop  in  1  one-cycle pulse; halt playback.
- WrEn  in  1  pattern write enable.
- WrAddr  in  log2(STEPS)  pattern step to write.
- WrData  in  12  note mask; bit 0 = C ... bit 11 = B.
- StepPeriod  in  CW  clocks per step; sampled at each step start.
- GateLen  in  CW  clocks from step start until notes are silenced; sampled at each step start.
- Select  out  12  registered note mask to the generator.
- nStart  out  1  registered, active-low oscillator restart.
- Step  out  log2(STEPS)  index of the step now playing.
- StepStrobe  out  1  one-cycle pulse at each step start.
- Playing  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, active-high):
  - state = IDLE, all pattern entries = 0, Step = 0.
  - Select = 0, nStart = 1, StepStrobe = 0, Playing = 0, counter = 0.
- States: IDLE, RESYNC, SOUND, REST. All outputs are registered and reflect the current state.
- IDLE: Select = 0, nStart = 1. A Start pulse sets Step = 0 and moves to RESYNC.
- RESYNC (exactly 1 cycle):
  - Outputs: nStart = 0, Select = 0, StepStrobe = 1, cnt = 0.
  - Latches mask = pattern[Step].
  - Latches P = max(StepPeriod, 2) and G = GateLen.
  - Next state: SOUND if G > 1, otherwise REST.
- SOUND: Select = mask, nStart = 1, cnt increments.
  - cnt reaches P-1 → advance.
  - Otherwise cnt+1 == G → REST.
- REST: Select = 0, cnt increments. cnt reaches P-1 → advance.
- Advance: Step = (Step+1) mod STEPS, wrapping STEPS-1 → 0; next state is RESYNC.
- Every step is therefore exactly P clocks long.
  - Select carries the mask for cnt in 1..min(G,P)-1.
  - G ≥ P gives a full-length step with no REST.
  - G ≤ 1 gives a silent step.
  - A zero mask gives a silent step with normal timing.
- Stop (any state): next cycle is IDLE, Select = 0, nStart = 1, Step is held (not cleared).
- Start and Stop in the same cycle: Stop wins.
- Start while playing: immediate restart; next cycle is RESYNC with Step = 0.
- Pattern writes:
  - Allowed in any state.
  - Write and read of the same entry in the same RESYNC cycle: RESYNC latches the new WrData.
  - A write to the playing step after RESYNC takes effect on that step's next pass.
- StepPeriod/GateLen changes mid-step have no effect until the next RESYNC.
- Counter width is CW. P ≤ 2^CW-1, so the counter never wraps inside a step.
- Reset asserted mid-playback: immediate return to reset values, pattern cleared.

Decomposition:
- Shared package `step_seq_pkg`:
  - state enum (IDLE, RESYNC, SOUND, REST).
  - NOTES = 12.
  - Note bit-position constants C..B.
  - Default STEPS and CW.
- One sub-module: `step_pattern_ram`.
  - STEPS x 12 register file, async-reset to 0.
  - Synchronous write, combinational read.
  - Write-through bypass when the read address equals the write address during a write.

Test Plan:
- Reset → Select=0, nStart=1, Playing=0, Step=0. Write pattern[0]=0x001 and pattern[1]=0x880, StepPeriod=8, GateLen=4, pulse Start → 1 cycle later: nStart=0, StepStrobe=1; then Select=0x001 for 3 cycles, 0 for 4 cycles; then RESYNC with Step=1, then Select=0x880 for 3 cycles.
- STEPS=16, StepPeriod=3, GateLen=100, all entries 0xFFF → Select=0xFFF for 2 of every 3 cycles; Step goes 15 → 0 wrap with a StepStrobe every 3 cycles.
- GateLen=1 and GateLen=0 → Select stays 0 all step; StepStrobe/nStart timing unchanged.
- StepPeriod=0 → treated as 2: RESYNC, then SOUND for 1 cycle, repeating.
- Stop during SOUND at Step=5 → next cycle IDLE, Select=0, Playing=0, Step=5. Start and Stop in the same cycle while IDLE → stays IDLE.
- Write pattern[Step] in the RESYNC cycle → new mask is output. StepPeriod changed mid-step → old length completes; new period applies from the next step. Reset mid-SOUND → all outputs at reset values, pattern reads 0.
